stream_demux: RTL and testbench
===============================

# stream_demux

Packet-level 1-to-N stream demultiplexer: the inverse of the codebase's N-to-1 multiplexers. It accepts one valid/ready input stream and routes each packet whole to the output channel named by `in_sel` on the packet's first beat. Each output has a one-entry registered slot. It sits between a shared producer, such as a receive front end, and per-channel consumers.

## Interface
- `N_OUT`, 4, number of output channels (2..16)
- `DATA_W`, 8, data beat width
- `SEL_W`, `$clog2(N_OUT)`, select width (derived, not overridden)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_data`  in  DATA_W  input beat
- `in_valid`  in  1  input beat valid
- `in_last`  in  1  final beat of packet
- `in_sel`  in  SEL_W  destination, sampled on first beat only
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`
- `out_data`  out  N_OUT*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- `out_valid`  out  N_OUT  per-channel valid
- `out_last`  out  N_OUT  per-channel last
- `out_ready`  in  N_OUT  per-channel ready
- `err_sel`  out  1  one-cycle pulse when a packet with `in_sel >= N_OUT` is accepted

## Operation
- FSM states: IDLE, ROUTE, DROP.
  - IDLE: the next accepted beat is a first beat. The beat's `in_sel` is latched into `dst`.
    - If `in_sel < N_OUT`, the beat goes to slot `in_sel`. Next state is ROUTE, or IDLE if `in_last`.
    - If `in_sel >= N_OUT`, the beat is consumed and discarded, and `err_sel` pulses. Next state is DROP, or IDLE if `in_last`.
  - ROUTE: beats go to slot `dst` and `in_sel` is ignored. An accepted beat with `in_last` returns the FSM to IDLE.
  - DROP: `in_ready` = 1 and beats are discarded. An accepted beat with `in_last` returns the FSM to IDLE.
- Target channel `t` is `in_sel` in IDLE and `dst` in ROUTE.
- `in_ready` (combinational) = `~out_valid[t] | out_ready[t]` in IDLE/ROUTE, and 1 in DROP or for an invalid select in IDLE.
- Slot k loads on an accepted routed beat targeting k and sets `out_valid[k]`.
- `out_valid[k]` clears when `out_ready[k]` is high and no new beat is loading into slot k.
- Simultaneous drain and load on the same slot: the new beat replaces the old one and `out_valid` stays 1, giving full throughput.
- Non-target slots drain independently. A stalled channel blocks only packets destined for it.
- `out_data` and `out_last` hold their value while `out_valid` is 0.

## Timing
- Reset values:
  - FSM state: IDLE; `dst` = 0.
  - `out_valid`, `out_data`, `out_last`: 0.
  - `err_sel`: 0.
  - Pulse counters (when compiled in): 0.
- Reset applies mid-packet: the partial packet is abandoned and the next beat after reset is treated as a first beat.
- Latency: 1 cycle from input acceptance to `out_valid` on the target channel.
- Throughput: 1 beat/cycle per packet when the target consumer keeps `out_ready` high.
- `err_sel` is registered and asserts the cycle after the first beat of a bad-select packet is accepted.
- Single-beat packet (`in_last` on first beat): the FSM stays in IDLE, and back-to-back packets to different channels proceed every cycle.
- `in_ready` has a combinational path from `in_sel`, `out_ready` and FSM state.

## Configuration
- `STREAM_DEMUX_STATS_EN`
- Defined: adds output `pkt_cnt`, width N_OUT*16.
  - Channel k's counter increments when a beat with `in_last` is loaded into slot k.
  - Counters wrap at 16'hFFFF → 0.
  - A separate output, `drop_cnt` (16 bits), increments on each accepted `in_last` beat while dropping, or for a single-beat bad-select packet.
- Undefined: `pkt_cnt` and `drop_cnt` ports and logic are absent, and all other behaviour is identical.

## Structure
- Package `stream_demux_pkg`:
  - state enum `demux_state_t` (IDLE, ROUTE, DROP)
  - `CNT_W` = 16
  - default `N_OUT` and `DATA_W` constants
- Sub-module `demux_slot`: one-entry register slice with DATA_W+1 bits payload, load/valid/ready. It is instantiated N_OUT times via generate.
- Top level holds the FSM, `dst` register, `in_ready` mux, `err_sel` and the optional counters.

## Test plan
- After reset: all `out_valid` = 0, `in_ready` = 1. Packet of 3 beats `in_sel=2` (data 8'hA1, A2, A3), `out_ready` all 1 → channel 2 emits A1, A2, A3 on consecutive cycles, each one cycle after acceptance, with `out_last` on A3.
- Mid-packet `in_sel` changes 2→0 on beats 2–3 → all beats still appear on channel 2 and channel 0 stays idle.
- `out_ready[1]` = 0, two beats sent to channel 1 → first beat held in the slot, `in_ready` = 0 on the second beat. Releasing `out_ready[1]` → second beat accepted and output next cycle, no data lost.
- With N_OUT = 3, packet with `in_sel=3` of 2 beats → both beats consumed, `err_sel` pulses once, no `out_valid`. The following packet with `in_sel=0` routes normally.
- Assert `rst` during beat 2 of a 4-beat packet → outputs clear immediately and the FSM is in IDLE. A new packet with `in_sel=1` after release routes to channel 1.
- With `STREAM_DEMUX_STATS_EN`: five single-beat packets to channel 3 → `pkt_cnt[3]` = 5. Preloading the counter at FFFF and sending one more packet → `pkt_cnt[3]` = 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the packet-level stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } demux_state_t;

  localparam int CNT_W      = 16;
  localparam int DEF_N_OUT  = 4;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot; 1-cycle latency, load may replace a draining entry.
// Backpressure: owner must only load when ~valid | ready, so nothing is overwritten while stalled.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  // dout only changes on load so it holds while valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N packet demux: first beat's in_sel picks the channel, 1-cycle latency via per-channel slots.
// in_ready tracks only the target slot; bad selects are swallowed. STREAM_DEMUX_STATS_EN adds counters.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N_OUT  = DEF_N_OUT,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  output logic [N_OUT-1:0]        out_last,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err_sel
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [N_OUT*CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt
`endif
);

  demux_state_t     state, state_nxt;
  logic [SEL_W-1:0] dst, tgt;
  logic             sel_ok, accept, routed, bad_first;
  logic [N_OUT-1:0] slot_free, load;

  assign sel_ok    = ({1'b0, in_sel} < (SEL_W+1)'(N_OUT));
  assign tgt       = (state == ROUTE) ? dst : in_sel;
  assign slot_free = ~out_valid | out_ready;

  // Dropped beats never touch a slot, so they are always accepted
  assign in_ready  = (state == DROP) ? 1'b1 :
                     ((state == IDLE) && !sel_ok) ? 1'b1 : slot_free[tgt];
  assign accept    = in_valid & in_ready;
  assign routed    = accept & ((state == ROUTE) | ((state == IDLE) & sel_ok));
  assign bad_first = accept & (state == IDLE) & ~sel_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (accept && !in_last) state_nxt = sel_ok ? ROUTE : DROP;
      ROUTE, DROP: if (accept && in_last)  state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dst     <= '0;
      err_sel <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_sel <= bad_first;
      if (accept && state == IDLE) dst <= in_sel;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    logic [DATA_W:0] q;

    assign load[k] = routed & (tgt == SEL_W'(k));

    demux_slot #(.W(DATA_W + 1)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   ({in_last, in_data}),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .dout  (q)
    );

    assign out_data[k*DATA_W +: DATA_W] = q[DATA_W-1:0];
    assign out_last[k]                  = q[DATA_W];
  end

`ifdef STREAM_DEMUX_STATS_EN
  // Packets are counted when their last beat lands in the slot
  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                      cnt <= '0;
      else if (load[k] && in_last)  cnt <= cnt + CNT_W'(1);
    end

    assign pkt_cnt[k*CNT_W +: CNT_W] = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (accept && in_last && (state == DROP || (state == IDLE && !sel_ok)))
      drop_cnt <= drop_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: vector table, directed corner sequences, random traffic vs a queue model.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [7:0]  a_data;
  logic        a_valid, a_last, a_ready, a_err;
  logic [1:0]  a_sel;
  logic [31:0] a_odata;
  logic [3:0]  a_ovalid, a_olast, a_oready;

  // 3-channel instance, where select value 3 is illegal
  logic [7:0]  b_data;
  logic        b_valid, b_last, b_ready, b_err;
  logic [1:0]  b_sel;
  logic [23:0] b_odata;
  logic [2:0]  b_ovalid, b_olast, b_oready;

`ifdef STREAM_DEMUX_STATS_EN
  logic [63:0] a_pkt;
  logic [15:0] a_drop;
  logic [47:0] b_pkt;
  logic [15:0] b_drop;
`endif

  stream_demux #(.N_OUT(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(a_data), .in_valid(a_valid), .in_last(a_last), .in_sel(a_sel),
    .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
    .out_last(a_olast), .out_ready(a_oready), .err_sel(a_err)
`ifdef STREAM_DEMUX_STATS_EN
    , .pkt_cnt(a_pkt), .drop_cnt(a_drop)
`endif
  );

  stream_demux #(.N_OUT(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(b_data), .in_valid(b_valid), .in_last(b_last), .in_sel(b_sel),
    .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid),
    .out_last(b_olast), .out_ready(b_oready), .err_sel(b_err)
`ifdef STREAM_DEMUX_STATS_EN
    , .pkt_cnt(b_pkt), .drop_cnt(b_drop)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v, l;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       e_rdy;
    logic [3:0] e_vld;
    int         e_ch;
    logic [7:0] e_d;
    logic       e_l;
  } vec_t;

  function automatic vec_t mk(logic v, logic l, logic [1:0] s, logic [7:0] d, logic [3:0] ordy,
                              logic er, logic [3:0] ev, int ch, logic [7:0] ed, logic el);
    vec_t r;
    r.v = v; r.l = l; r.sel = s; r.d = d; r.ordy = ordy;
    r.e_rdy = er; r.e_vld = ev; r.e_ch = ch; r.e_d = ed; r.e_l = el;
    return r;
  endfunction

  vec_t tbl[16];

  // Random-phase reference: per-channel expected beat queues ({last,data})
  logic [8:0] q[3][$];
  int  err_exp, err_seen;
  bit  m_first;
  int  m_ch;

  task automatic sample_b();
    logic [8:0] exp_beat;
    for (int k = 0; k < 3; k++) begin
      if (b_ovalid[k] && b_oready[k]) begin
        if (q[k].size() == 0) begin
          check($sformatf("rand ch%0d unexpected beat", k), {b_olast[k], b_odata[k*8 +: 8]}, 9'h1FF);
        end else begin
          exp_beat = q[k].pop_front();
          check($sformatf("rand ch%0d beat", k), {b_olast[k], b_odata[k*8 +: 8]}, exp_beat);
        end
      end
    end
    if (b_err) err_seen++;
    if (b_valid && b_ready) begin
      if (m_first) m_ch = int'(b_sel);
      if (m_ch < 3)     q[m_ch].push_back({b_last, b_data});
      else if (m_first) err_exp++;
      m_first = b_last;
    end
  endtask

  initial begin
    bit         pending;
    int         rem;
    logic [1:0] gsel;

    rst = 1'b1;
    a_valid = 0; a_last = 0; a_sel = 0; a_data = 0; a_oready = 4'hF;
    b_valid = 0; b_last = 0; b_sel = 0; b_data = 0; b_oready = 3'h7;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset dut3 out_valid", b_ovalid, 3'b000);
    check("reset err_sel", a_err, 1'b0);

    tbl[0]  = mk(0, 0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 0, 8'h00, 0);
    tbl[1]  = mk(1, 0, 2'd2, 8'hA1, 4'hF, 1, 4'b0100, 2, 8'hA1, 0);
    tbl[2]  = mk(1, 0, 2'd0, 8'hA2, 4'hF, 1, 4'b0100, 2, 8'hA2, 0);
    tbl[3]  = mk(1, 1, 2'd0, 8'hA3, 4'hF, 1, 4'b0100, 2, 8'hA3, 1);
    tbl[4]  = mk(0, 0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 2, 8'hA3, 1);
    tbl[5]  = mk(1, 0, 2'd1, 8'hB1, 4'hD, 1, 4'b0010, 1, 8'hB1, 0);
    tbl[6]  = mk(1, 1, 2'd1, 8'hB2, 4'hD, 0, 4'b0010, 1, 8'hB1, 0);
    tbl[7]  = mk(1, 1, 2'd1, 8'hB2, 4'hF, 1, 4'b0010, 1, 8'hB2, 1);
    tbl[8]  = mk(0, 0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 1, 8'hB2, 1);
    tbl[9]  = mk(1, 1, 2'd0, 8'hC0, 4'hF, 1, 4'b0001, 0, 8'hC0, 1);
    tbl[10] = mk(1, 1, 2'd3, 8'hC3, 4'hF, 1, 4'b1000, 3, 8'hC3, 1);
    tbl[11] = mk(1, 1, 2'd1, 8'hC1, 4'hF, 1, 4'b0010, 1, 8'hC1, 1);
    tbl[12] = mk(1, 1, 2'd3, 8'hD3, 4'h7, 1, 4'b1000, 3, 8'hD3, 1);
    tbl[13] = mk(1, 1, 2'd3, 8'hD4, 4'h7, 0, 4'b1000, 3, 8'hD3, 1);
    tbl[14] = mk(1, 1, 2'd0, 8'hE0, 4'h7, 1, 4'b1001, 0, 8'hE0, 1);
    tbl[15] = mk(0, 0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 3, 8'hD3, 1);

    for (int i = 0; i < 16; i++) begin
      a_valid = tbl[i].v; a_last = tbl[i].l; a_sel = tbl[i].sel;
      a_data = tbl[i].d; a_oready = tbl[i].ordy;
      #1 check($sformatf("row%0d in_ready", i), a_ready, tbl[i].e_rdy);
      @(posedge clk); #1;
      check($sformatf("row%0d out_valid", i), a_ovalid, tbl[i].e_vld);
      check($sformatf("row%0d data", i), a_odata[tbl[i].e_ch*8 +: 8], tbl[i].e_d);
      check($sformatf("row%0d last", i), a_olast[tbl[i].e_ch], tbl[i].e_l);
    end

    // Reset during beat 2 of a 4-beat packet
    a_valid = 1; a_sel = 2; a_last = 0; a_data = 8'hF1; a_oready = 4'hF;
    @(posedge clk); #1;
    check("pre-rst out_valid", a_ovalid, 4'b0100);
    a_data = 8'hF2;
    #2 rst = 1'b1;
    #1;
    check("rst out_valid", a_ovalid, 4'b0000);
    check("rst ch2 data", a_odata[23:16], 8'h00);
    a_valid = 0;
    @(posedge clk); #1 rst = 1'b0;
    a_valid = 1; a_sel = 1; a_last = 1; a_data = 8'h61;
    #1 check("post-rst in_ready", a_ready, 1'b1);
    @(posedge clk); #1;
    check("post-rst out_valid", a_ovalid, 4'b0010);
    check("post-rst ch1 data", a_odata[15:8], 8'h61);
    a_valid = 0;

`ifdef STREAM_DEMUX_STATS_EN
    a_valid = 1; a_sel = 3; a_last = 1; a_data = 8'h33;
    repeat (5) @(posedge clk);
    #1 a_valid = 0;
    check("pkt_cnt[3] five", a_pkt[63:48], 16'd5);
    check("pkt_cnt[1] one", a_pkt[31:16], 16'd1);
    a_valid = 1;
    repeat (65530) @(posedge clk);
    #1 check("pkt_cnt[3] max", a_pkt[63:48], 16'hFFFF);
    @(posedge clk);
    #1 a_valid = 0;
    check("pkt_cnt[3] wrap", a_pkt[63:48], 16'h0000);
`endif

    // Bad select on the 3-channel instance, then a good packet
    b_oready = 3'b111; b_valid = 1; b_sel = 3; b_last = 0; b_data = 8'h11;
    #1 check("bad first in_ready", b_ready, 1'b1);
    @(posedge clk); #1;
    check("bad err_sel pulse", b_err, 1'b1);
    check("bad beat1 out_valid", b_ovalid, 3'b000);
    b_sel = 0; b_last = 1; b_data = 8'h12;
    #1 check("drop in_ready", b_ready, 1'b1);
    @(posedge clk); #1;
    check("drop err_sel low", b_err, 1'b0);
    check("drop out_valid", b_ovalid, 3'b000);
`ifdef STREAM_DEMUX_STATS_EN
    check("drop_cnt", b_drop, 16'd1);
`endif
    b_sel = 0; b_last = 1; b_data = 8'h13;
    @(posedge clk); #1;
    check("after drop out_valid", b_ovalid, 3'b001);
    check("after drop ch0 data", b_odata[7:0], 8'h13);
    b_valid = 0;
    @(posedge clk); #1;

    // Random traffic on the 3-channel instance
    err_exp = 0; err_seen = 0; m_first = 1; m_ch = 0;
    pending = 0; rem = 0; gsel = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        b_valid = 0;
        if (rem == 0) begin
          gsel  = 2'($urandom_range(0, 3));
          rem   = $urandom_range(1, 4);
          b_sel = gsel;
        end else begin
          b_sel = 2'($urandom_range(0, 3));
        end
        b_data  = 8'($urandom);
        b_last  = (rem == 1);
        pending = 1;
      end
      if (!b_valid) b_valid = ($urandom_range(0, 3) != 0);
      b_oready = 3'($urandom);
      @(negedge clk);
      if (b_valid && b_ready) begin
        pending = 0;
        rem--;
      end
      sample_b();
      @(posedge clk); #1;
    end
    b_valid = 0; b_oready = 3'b111;
    repeat (4) begin
      @(negedge clk);
      sample_b();
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++)
      check($sformatf("rand ch%0d leftover", k), q[k].size(), 0);
    check("rand err_sel pulses", err_seen, err_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
